// File: rtl/mul_arbiter_pkg.sv
// Shared types and helpers for the multiplier arbiter slice.
// Holds the FSM encoding, default widths and a popcount helper.
package mul_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        COUNT,
        RESP
    } state_t;

    localparam int AW_DEF  = 24;
    localparam int RW_DEF  = 32;
    localparam int ONES_W  = 6;
    localparam int OPCNT_W = 16;

    function automatic logic [ONES_W-1:0] popcount(input logic [63:0] v);
        logic [ONES_W:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + (ONES_W + 1)'(v[i]);
        end
        return n[ONES_W-1:0];
    endfunction

endpackage

// File: rtl/mul_engine.sv
// Sequential shift-add multiplier with a one-cycle popcount stage.
// done pulses on the last multiply cycle; results land one cycle later.
module mul_engine
    import mul_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW-1:0]     a1,
    input  logic [AW-1:0]     a2,
    output logic              done,
    output logic [RW-1:0]     w,
    output logic [ONES_W-1:0] ones,
    output logic              ovf
);

    localparam int KW = $clog2(AW);

    logic [AW-1:0]   a1_q;
    logic [AW-1:0]   a2_q;
    logic [2*AW-1:0] acc;
    logic [KW-1:0]   k;
    logic            run;
    logic            cnt;

    assign done = run && (k == KW'(AW - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            a1_q <= '0;
            a2_q <= '0;
            acc  <= '0;
            k    <= '0;
            run  <= 1'b0;
            cnt  <= 1'b0;
            w    <= '0;
            ones <= '0;
            ovf  <= 1'b0;
        end else begin
            cnt <= 1'b0;
            if (start) begin
                a1_q <= a1;
                a2_q <= a2;
                acc  <= '0;
                k    <= '0;
                run  <= 1'b1;
            end else if (run) begin
                // full-width partial product, never truncated
                if (a2_q[k]) begin
                    acc <= acc + ({{AW{1'b0}}, a1_q} << k);
                end
                k <= k + KW'(1);
                if (done) begin
                    run <= 1'b0;
                    cnt <= 1'b1;
                end
            end else if (cnt) begin
                w    <= acc[RW-1:0];
                ones <= popcount(64'(acc[RW-1:0]));
                ovf  <= |acc[2*AW-1:RW];
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin front end sharing one mul_engine between NREQ requesters.
// Handles request/response handshakes, requester tagging and op counting.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = AW_DEF,
    parameter int RW   = RW_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*AW-1:0]       req_a1,
    input  logic [NREQ*AW-1:0]       req_a2,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [RW-1:0]            rsp_w,
    output logic [ONES_W-1:0]        rsp_ones,
    output logic                     rsp_ovf,
    output logic                     busy,
    output logic [OPCNT_W-1:0]       op_count
);

    localparam int IW = $clog2(NREQ);

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] id_q;
    logic          found;
    logic          accept;
    logic          eng_done;
    int            j;

    // first pending requester at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req_valid[j]) begin
                found = 1'b1;
                win   = IW'(j);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        unique case (state)
            IDLE: begin
                if (found && !reset) begin
                    req_ready = NREQ'(1) << win;
                    state_nx  = MULT;
                end
            end
            MULT: begin
                if (eng_done) begin
                    state_nx = COUNT;
                end
            end
            COUNT: begin
                state_nx = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    assign accept    = |(req_valid & req_ready);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            id_q     <= '0;
            rsp_id   <= '0;
            op_count <= '0;
        end else begin
            if (accept) begin
                id_q <= win;
                ptr  <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
            end
            if (state == COUNT) begin
                rsp_id <= id_q;
            end
            if (rsp_valid && rsp_ready) begin
                op_count <= op_count + OPCNT_W'(1);
            end
        end
    end

    mul_engine #(
        .AW (AW),
        .RW (RW)
    ) u_engine (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .a1    (req_a1[int'(win)*AW +: AW]),
        .a2    (req_a2[int'(win)*AW +: AW]),
        .done  (eng_done),
        .w     (rsp_w),
        .ones  (rsp_ones),
        .ovf   (rsp_ovf)
    );

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one sequential 24x24 multiply + popcount engine between NREQ bus-side requesters.
- Arbitrates round-robin and accepts operands through a valid/ready handshake.
- Sequences the engine through shift-add multiply and ones-count.
- Returns the low 32-bit result, ones count and overflow flag on a shared response port tagged with the requester id.
- Sits between the register-decode logic of the GPIO emulator and the arithmetic datapath.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 24, operand width
- RW, 32, returned result width (product width is 2*AW)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request; held high until accepted
- req_ready  out  NREQ  one-hot grant/accept; accept occurs when req_valid[i] and req_ready[i] are both high
- req_a1  in  NREQ*AW  operand A1, requester i at bits [i*AW +: AW]
- req_a2  in  NREQ*AW  operand A2, same packing
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer accepts
- rsp_id  out  $clog2(NREQ)  requester that owns the response
- rsp_w  out  RW  product[RW-1:0]
- rsp_ones  out  6  number of ones in rsp_w (0..32)
- rsp_ovf  out  1  1 when product[2*AW-1:RW] is nonzero
- busy  out  1  state != IDLE
- op_count  out  16  completed operations, wraps 0xFFFF -> 0

Behaviour:
- Reset (sampled at clk edge while reset=1):
  - state=IDLE, rr pointer=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_w=0, rsp_ones=0, rsp_ovf=0, busy=0, op_count=0.
  - Reset dominates every other event, including mid-MULT and mid-RESP; any in-flight operation is discarded with no response.
- States:
  - IDLE: req_ready is combinational and one-hot on the winner, which is the first i with req_valid[i] set, searching ptr, ptr+1, ... modulo NREQ. If no request is pending, req_ready=0. On accept: latch A1 and A2, latch id=winner, set ptr to (winner+1) mod NREQ, clear the accumulator and bit index, go to MULT.
  - MULT: exactly AW cycles. Bit index k runs 0..AW-1. If A2[k]=1, accumulator += A1<<k, computed at 2*AW bits with no truncation. After k=AW-1, go to COUNT.
  - COUNT: 1 cycle. Register rsp_w=acc[RW-1:0], rsp_ones=popcount(acc[RW-1:0]), rsp_ovf=|acc[2*AW-1:RW], rsp_id=id. Go to RESP.
  - RESP: rsp_valid=1. rsp_id, rsp_w, rsp_ones and rsp_ovf are held stable until rsp_ready=1. On the response handshake: op_count+1, rsp_valid=0 next cycle, go to IDLE.
- Latency: an accept in cycle T gives rsp_valid high from T+AW+2 (T+26 at the default parameters).
- Throughput: at most one operation in flight. req_ready=0 in every state except IDLE.
- With rsp_ready tied high, the next accept can occur at the earliest in T+AW+3.
- Operands are sampled only at accept. Later changes on req_a1/req_a2 have no effect.
- Dropping req_valid before accept is permitted: that requester is simply skipped.
- Requesters are granted only while in IDLE; a request arriving in a later state waits for the next arbitration.
- A requester re-raising req_valid immediately after its own grant is served after every other pending requester (round-robin fairness).
- Zero operand: accumulator stays 0; rsp_w=0, ones=0, ovf=0; latency unchanged.
- Outputs not listed above keep their value outside reset.

Decomposition:
- Package mul_arbiter_pkg:
  - state enum {IDLE, MULT, COUNT, RESP}
  - localparams AW_DEF=24, RW_DEF=32, ONES_W=6, OPCNT_W=16
  - popcount function
- Sub-module mul_engine: owns the operand registers, accumulator, bit index and popcount.
  - Inputs: start, a1, a2.
  - Outputs: done pulse, w, ones, ovf.
  - Arbitration, round-robin pointer, handshakes and op_count stay in mul_arbiter.

Test Plan:
1. Single request: req0 with A1=3, A2=5 -> accepted cycle T; rsp_valid at T+26; rsp_w=0x0000000F, ones=4, ovf=0, id=0; op_count=1 after handshake.
2. Overflow: A1=A2=0xFFFFFF -> product 0xFFFFFE000001; rsp_w=0xFE000001, ones=8, ovf=1.
3. Round-robin with all four requesting continuously -> grant order 0,1,2,3,0; then only req1 and req3 valid with ptr=1 -> order 1,3; exactly one req_ready bit high per accept.
4. Backpressure: rsp_ready low for 5 cycles while other requests are pending -> rsp fields stable, req_ready=0, busy=1; the grant occurs only after the response handshake.
5. Reset mid-MULT: reset asserted at T+10 with a fully operating unit -> next cycle busy=0, rsp_valid=0, op_count=0; the held req0 is re-accepted and its response is correct.
6. Zero and operand hold: A1=0, A2=0xABCDEF -> rsp_w=0, ones=0, ovf=0 at T+26. Changing req_a1 after accept to 7 does not alter the result.
